// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 16-bit five-stage pipeline.
// Holds the PC and drives the instruction-memory request. Presents at most one
// instruction per cycle to the FD register under a valid/stall handshake.
// On a memory hit the instruction is presented in the same cycle, so the
// datapath outputs are combinational from state plus the memory response.
// A stalled hit is parked in a one-entry buffer. A redirect that lands during
// a miss waits in DRAIN until the outstanding request completes, because the
// address must stay stable while a request is open.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_done,
    input  logic [15:0] i_imem_rdata,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc_inc,
    output logic        o_valid
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_tgt;
    logic [15:0] w_tgt_nxt;
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc_inc;
    logic        r_halt_pend;
    logic        w_halt_pend_nxt;
    logic        w_buf_load;
    logic [15:0] w_pc_plus2;

    // Modulo-2^16 increment: 16'hFFFE wraps to 16'h0000 silently.
    assign w_pc_plus2 = r_pc + 16'd2;

    // Next-state, PC, target and halt-pending decisions; redirect outranks halt and stall.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_tgt_nxt       = r_tgt;
        w_halt_pend_nxt = r_halt_pend;
        w_buf_load      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_redirect) begin
                    w_halt_pend_nxt = 1'b0;
                    if (i_imem_done) begin
                        w_pc_nxt    = i_redirect_pc;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_tgt_nxt   = i_redirect_pc;
                        w_state_nxt = S_DRAIN;
                    end
                end else if (i_halt) begin
                    if (i_imem_done) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        // Let the open request finish, then park without refetching.
                        w_halt_pend_nxt = 1'b1;
                        w_tgt_nxt       = r_pc;
                        w_state_nxt     = S_DRAIN;
                    end
                end else if (i_imem_done) begin
                    w_pc_nxt = w_pc_plus2;
                    if (i_stall) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    w_halt_pend_nxt = 1'b0;
                    w_pc_nxt        = i_redirect_pc;
                    w_state_nxt     = S_FETCH;
                end else if (i_halt) begin
                    w_state_nxt = S_HALT;
                end else if (!i_stall) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (i_redirect) begin
                    // Newest target wins; a pending halt is superseded.
                    w_halt_pend_nxt = 1'b0;
                    w_tgt_nxt       = i_redirect_pc;
                    if (i_imem_done) begin
                        w_pc_nxt    = i_redirect_pc;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (i_imem_done) begin
                    w_pc_nxt        = r_tgt;
                    w_halt_pend_nxt = 1'b0;
                    w_state_nxt     = r_halt_pend ? S_HALT : S_FETCH;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_HALT: begin
                if (i_redirect) begin
                    w_halt_pend_nxt = 1'b0;
                    w_pc_nxt        = i_redirect_pc;
                    w_state_nxt     = S_FETCH;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Control state, PC, target and halt-pending registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_tgt       <= RESET_PC;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_tgt       <= w_tgt_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    // One-entry skid buffer for a hit that arrives while downstream is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf_instr  <= NOP_INSTR;
            r_buf_pc_inc <= 16'h0000;
        end else if (w_buf_load) begin
            r_buf_instr  <= i_imem_rdata;
            r_buf_pc_inc <= w_pc_plus2;
        end else begin
            r_buf_instr  <= r_buf_instr;
            r_buf_pc_inc <= r_buf_pc_inc;
        end
    end

    // Request and FD-facing outputs; a redirect or halt suppresses valid in its own cycle.
    always_comb begin
        o_imem_req  = 1'b0;
        o_imem_addr = r_pc;
        o_valid     = 1'b0;
        o_instr     = NOP_INSTR;
        o_pc_inc    = 16'h0000;
        if (i_rst) begin
            o_imem_req = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_done && !i_redirect && !i_halt) begin
                        o_valid  = 1'b1;
                        o_instr  = i_imem_rdata;
                        o_pc_inc = w_pc_plus2;
                    end else begin
                        o_valid = 1'b0;
                    end
                end
                S_HOLD: begin
                    o_imem_req = 1'b0;
                    if (!i_redirect && !i_halt) begin
                        o_valid  = 1'b1;
                        o_instr  = r_buf_instr;
                        o_pc_inc = r_buf_pc_inc;
                    end else begin
                        o_valid = 1'b0;
                    end
                end
                S_DRAIN: begin
                    o_imem_req = 1'b1;
                end
                S_HALT: begin
                    o_imem_req = 1'b0;
                end
                default: begin
                    o_imem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The memory model answers each request
// after a fixed or random latency. The random test checks the stream of
// accepted instructions against an expected-PC sequence model.
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        i_halt;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_done;
    logic [15:0] i_imem_rdata;
    logic [15:0] o_instr;
    logic [15:0] o_pc_inc;
    logic        o_valid;

    int   total;
    int   passed;
    int   fix_lat;
    int   mem_left;
    logic mem_pending;

    localparam logic [15:0] NOP = 16'h0800;

    fetch_stage dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_done   (i_imem_done),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_pc_inc      (o_pc_inc),
        .o_valid       (o_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // One cycle: at the falling edge drive inputs and answer the memory, then sample 1ns later.
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic hl);
        @(negedge i_clk);
        i_stall       = st;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_halt        = hl;
        if (o_imem_req) begin
            if (!mem_pending) begin
                mem_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            end
            if (mem_left == 0) begin
                i_imem_done  = 1'b1;
                i_imem_rdata = mem_word(o_imem_addr);
                mem_pending  = 1'b0;
            end else begin
                i_imem_done  = 1'b0;
                i_imem_rdata = 16'($urandom);
                mem_left     = mem_left - 1;
                mem_pending  = 1'b1;
            end
        end else begin
            i_imem_done  = 1'b0;
            i_imem_rdata = 16'($urandom);
            mem_pending  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] a;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_valid, o_instr, o_pc_inc} !== {1'b0, 1'b0, NOP, 16'h0000}) begin
            $display("FAIL reset_state: got req=%b valid=%b instr=%h pc_inc=%h, want 0/0/0800/0000",
                     o_imem_req, o_valid, o_instr, o_pc_inc);
        end else passed++;
        i_rst = 1'b0;
        fix_lat = 0;
        for (int i = 0; i < 3; i++) begin
            a = 16'(2 * i);
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !==
                {1'b1, a, 1'b1, mem_word(a), 16'(a + 16'd2)}) begin
                $display("FAIL reset_hit%0d: got req=%b addr=%h valid=%b instr=%h pc_inc=%h, want addr=%h pc_inc=%h",
                         i, o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc, a, 16'(a + 16'd2));
            end else passed++;
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b1, 16'h0010, 1'b0);
        total++;
        if (o_valid !== 1'b0) begin
            $display("FAIL stall_redirect_valid: got %b want 0", o_valid);
        end else passed++;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !==
            {1'b1, 16'h0010, 1'b1, mem_word(16'h0010), 16'h0012}) begin
            $display("FAIL stall_hit: got req=%b addr=%h valid=%b instr=%h pc_inc=%h want 1/0010/1/%h/0012",
                     o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc, mem_word(16'h0010));
        end else passed++;
        for (int k = 0; k < 3; k++) begin
            step((k < 2) ? 1'b1 : 1'b0, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({o_imem_req, o_valid, o_instr, o_pc_inc} !== {1'b0, 1'b1, mem_word(16'h0010), 16'h0012}) begin
                $display("FAIL stall_hold%0d: got req=%b valid=%b instr=%h pc_inc=%h want 0/1/%h/0012",
                         k, o_imem_req, o_valid, o_instr, o_pc_inc, mem_word(16'h0010));
            end else passed++;
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_pc_inc} !== {1'b1, 16'h0012, 1'b1, 16'h0014}) begin
            $display("FAIL stall_resume: got req=%b addr=%h valid=%b pc_inc=%h want 1/0012/1/0014",
                     o_imem_req, o_imem_addr, o_valid, o_pc_inc);
        end else passed++;
    endtask

    task automatic test_miss_redirect();
        step(1'b0, 1'b1, 16'h0020, 1'b0);
        fix_lat = 3;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, (c == 1) ? 1'b1 : 1'b0, 16'h0100, 1'b0);
            fix_lat = 0;
            total++;
            if ({o_imem_req, o_imem_addr, o_valid, o_instr} !== {1'b1, 16'h0020, 1'b0, NOP}) begin
                $display("FAIL miss_cycle%0d: got req=%b addr=%h valid=%b instr=%h want 1/0020/0/0800",
                         c, o_imem_req, o_imem_addr, o_valid, o_instr);
            end else passed++;
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !==
            {1'b1, 16'h0100, 1'b1, mem_word(16'h0100), 16'h0102}) begin
            $display("FAIL miss_target: got req=%b addr=%h valid=%b instr=%h pc_inc=%h want 1/0100/1/%h/0102",
                     o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc, mem_word(16'h0100));
        end else passed++;
    endtask

    task automatic test_redirect_halt();
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        total++;
        if (o_valid !== 1'b0) begin
            $display("FAIL rdhalt_valid: got %b want 0", o_valid);
        end else passed++;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({o_imem_req, o_imem_addr, o_valid, o_pc_inc} !==
                {1'b1, 16'(16'h0040 + 16'(2 * c)), 1'b1, 16'(16'h0042 + 16'(2 * c))}) begin
                $display("FAIL rdhalt_fetch%0d: got req=%b addr=%h valid=%b pc_inc=%h",
                         c, o_imem_req, o_imem_addr, o_valid, o_pc_inc);
            end else passed++;
        end
    endtask

    task automatic test_halt_hold();
        step(1'b0, 1'b1, 16'h0030, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_valid, o_pc_inc} !== {1'b1, 16'h0032}) begin
            $display("FAIL hhold_hit: got valid=%b pc_inc=%h want 1/0032", o_valid, o_pc_inc);
        end else passed++;
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({o_imem_req, o_valid, o_instr} !== {1'b0, 1'b0, NOP}) begin
                $display("FAIL hhold_halted%0d: got req=%b valid=%b instr=%h want 0/0/0800",
                         c, o_imem_req, o_valid, o_instr);
            end else passed++;
        end
        step(1'b0, 1'b1, 16'h0200, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !==
            {1'b1, 16'h0200, 1'b1, mem_word(16'h0200), 16'h0202}) begin
            $display("FAIL hhold_resume: got req=%b addr=%h valid=%b instr=%h pc_inc=%h want 1/0200/1/%h/0202",
                     o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc, mem_word(16'h0200));
        end else passed++;
    endtask

    task automatic test_halt_miss();
        step(1'b0, 1'b1, 16'h0060, 1'b0);
        fix_lat = 2;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 16'h0000, (c == 0) ? 1'b1 : 1'b0);
            total++;
            if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 16'h0060, 1'b0}) begin
                $display("FAIL hmiss_drain%0d: got req=%b addr=%h valid=%b want 1/0060/0",
                         c, o_imem_req, o_imem_addr, o_valid);
            end else passed++;
        end
        fix_lat = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({o_imem_req, o_valid} !== {1'b0, 1'b0}) begin
                $display("FAIL hmiss_halted%0d: got req=%b valid=%b want 0/0", c, o_imem_req, o_valid);
            end else passed++;
        end
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_pc_inc} !== {1'b1, 16'h0300, 1'b1, 16'h0302}) begin
            $display("FAIL hmiss_resume: got req=%b addr=%h valid=%b pc_inc=%h want 1/0300/1/0302",
                     o_imem_req, o_imem_addr, o_valid, o_pc_inc);
        end else passed++;
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 16'hFFFE, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !==
            {1'b1, 16'hFFFE, 1'b1, mem_word(16'hFFFE), 16'h0000}) begin
            $display("FAIL wrap_hit: got req=%b addr=%h valid=%b instr=%h pc_inc=%h want 1/fffe/1/%h/0000",
                     o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc, mem_word(16'hFFFE));
        end else passed++;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_pc_inc} !== {1'b1, 16'h0000, 16'h0002}) begin
            $display("FAIL wrap_next: got req=%b addr=%h pc_inc=%h want 1/0000/0002",
                     o_imem_req, o_imem_addr, o_pc_inc);
        end else passed++;
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 16'h0080, 1'b0);
        fix_lat = 5;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 16'h0080, 1'b0}) begin
            $display("FAIL areset_miss: got req=%b addr=%h valid=%b want 1/0080/0",
                     o_imem_req, o_imem_addr, o_valid);
        end else passed++;
        i_rst = 1'b1;
        #1;
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc} !== {1'b0, 16'h0000, 1'b0, NOP, 16'h0000}) begin
            $display("FAIL areset_now: got req=%b addr=%h valid=%b instr=%h pc_inc=%h want 0/0000/0/0800/0000",
                     o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_inc);
        end else passed++;
        mem_pending = 1'b0;
        #1;
        i_rst = 1'b0;
        fix_lat = 0;
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        total++;
        if ({o_imem_req, o_imem_addr, o_valid, o_pc_inc} !== {1'b1, 16'h0000, 1'b1, 16'h0002}) begin
            $display("FAIL areset_restart: got req=%b addr=%h valid=%b pc_inc=%h want 1/0000/1/0002",
                     o_imem_req, o_imem_addr, o_valid, o_pc_inc);
        end else passed++;
    endtask

    // Random stall, latency and redirects; accepted stream must follow the expected PC sequence.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] rpc;
        logic        st;
        logic        rd;
        logic        p_pend;
        logic [15:0] p_addr;
        logic        p_sv;
        logic [15:0] p_instr;
        logic [15:0] p_pcinc;
        fix_lat = -1;
        exp_pc  = 16'h0000;
        p_sv    = 1'b0;
        p_instr = 16'h0000;
        p_pcinc = 16'h0000;
        for (int n = 0; n < 300; n++) begin
            st  = ($urandom_range(0, 2) == 0);
            rd  = (n == 0) || ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom) & 16'hFFFE;
            p_pend = mem_pending;
            p_addr = o_imem_addr;
            step(st, rd, rpc, 1'b0);
            if (p_pend) begin
                total++;
                if ({o_imem_req, o_imem_addr} !== {1'b1, p_addr}) begin
                    $display("FAIL rnd_addr_stable@%0d: got req=%b addr=%h want 1/%h", n, o_imem_req, o_imem_addr, p_addr);
                end else passed++;
            end
            if (rd) begin
                total++;
                if (o_valid !== 1'b0) begin
                    $display("FAIL rnd_redirect_valid@%0d: got %b want 0", n, o_valid);
                end else passed++;
                exp_pc = rpc;
            end else begin
                if (p_sv) begin
                    total++;
                    if ({o_valid, o_instr, o_pc_inc} !== {1'b1, p_instr, p_pcinc}) begin
                        $display("FAIL rnd_stall_stable@%0d: got valid=%b instr=%h pc_inc=%h want 1/%h/%h",
                                 n, o_valid, o_instr, o_pc_inc, p_instr, p_pcinc);
                    end else passed++;
                end
                if (o_valid === 1'b1 && !st) begin
                    total++;
                    if ({o_instr, o_pc_inc} !== {mem_word(exp_pc), 16'(exp_pc + 16'd2)}) begin
                        $display("FAIL rnd_accept@%0d: got instr=%h pc_inc=%h want %h/%h",
                                 n, o_instr, o_pc_inc, mem_word(exp_pc), 16'(exp_pc + 16'd2));
                    end else passed++;
                    exp_pc = exp_pc + 16'd2;
                end
            end
            if (o_valid !== 1'b1) begin
                total++;
                if (o_instr !== NOP) begin
                    $display("FAIL rnd_nop@%0d: got instr=%h want 0800", n, o_instr);
                end else passed++;
            end
            p_sv    = (o_valid === 1'b1) && st;
            p_instr = o_instr;
            p_pcinc = o_pc_inc;
        end
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        fix_lat       = 0;
        mem_left      = 0;
        mem_pending   = 1'b0;
        i_rst         = 1'b1;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;
        i_halt        = 1'b0;
        i_imem_done   = 1'b0;
        i_imem_rdata  = 16'h0000;
        test_reset();
        test_stall();
        test_miss_redirect();
        test_redirect_halt();
        test_halt_hold();
        test_halt_miss();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipeline. Holds the PC, drives the instruction-memory request, and presents one instruction per cycle to the fetch/decode pipeline register under a valid/stall handshake. It absorbs multi-cycle memory misses, downstream stalls, branch redirects and HALT, and never emits an instruction from a cancelled path.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- NOP_INSTR, 16'h0800, encoding driven on `instr` whenever `valid`=0
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  downstream cannot accept; an instruction is accepted on a rising edge with `valid`=1 and `stall`=0
- redirect  in  1  branch/jump resolved taken; cancels all fetched-but-unaccepted work
- redirect_pc  in  16  target PC, sampled when `redirect`=1
- halt  in  1  decode has seen HALT; stop fetching
- imem_req  out  1  memory request; once raised, held with stable `imem_addr` until `imem_done`
- imem_addr  out  16  fetch address
- imem_done  in  1  `imem_rdata` valid this cycle; may coincide with the first request cycle (hit)
- imem_rdata  in  16  fetched instruction
- instr  out  16  instruction to FD register
- pc_inc  out  16  fetch PC + 2 of `instr`
- valid  out  1  `instr`/`pc_inc` are a real instruction

## Operation
- Registers: `pc`, `tgt`, `buf_instr`, `buf_pc_inc`, `halt_pend`, 2-bit state {FETCH, HOLD, DRAIN, HALT}.
- Reset: state FETCH, `pc`=RESET_PC, `halt_pend`=0; `imem_req`=0 while `rst`=1; `valid`=0, `instr`=NOP_INSTR, `pc_inc`=0.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_done`: `instr`=`imem_rdata`, `pc_inc`=`pc`+2, `valid`=1 (combinational), `pc`<=`pc`+2; if also `stall`, capture into buffer and go HOLD. If not `imem_done`: `valid`=0, stay.
- HOLD: `imem_req`=0; outputs from buffer with `valid`=1; leave to FETCH on the edge with `stall`=0.
- DRAIN: `imem_req`=1 with the stale `pc`; `valid`=0; on `imem_done` discard data, `pc`<=`tgt`, go FETCH, or HALT if `halt_pend`.
- HALT: `imem_req`=0, `valid`=0; exits only on `redirect` or reset.
- Redirect (priority over stall and halt; halt in the same cycle is ignored and `halt_pend` is cleared):
  - In FETCH with `imem_done`, HOLD, or HALT: `valid` forced 0 this cycle, `pc`<=`redirect_pc`, go FETCH.
  - In FETCH without `imem_done`: `tgt`<=`redirect_pc`, go DRAIN.
  - In DRAIN: `tgt` overwritten; the newest target wins. If `imem_done` in the same cycle, `pc`<=`redirect_pc`, go FETCH.
- Halt (no redirect):
  - In FETCH with `imem_done`: `valid`=0, `pc` held, go HALT.
  - In FETCH without `imem_done`: `halt_pend`<=1, `tgt`<=`pc`, go DRAIN.
  - In HOLD: buffer dropped, go HALT.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000, with no flag.

## Timing
- Hit: fetch-to-output latency 0 cycles, throughput 1 instruction/cycle.
- Miss of N cycles: `valid` rises in the cycle `imem_done` arrives.
- Redirect to first target request: next cycle. Out of DRAIN: cycle after `imem_done`.
- Stall: outputs bit-stable for every stalled cycle. No instruction is lost or duplicated.
- `imem_addr` never changes while `imem_req`=1 and `imem_done`=0.
- Async reset mid-miss: state and PC reset immediately and `imem_req` drops. The memory model must tolerate an abandoned request.

## Test plan
- Reset, hit every cycle: accepted sequence pc_inc = 0x0002, 0x0004, 0x0006 on consecutive edges; `imem_addr` = 0x0000, 0x0002, 0x0004.
- Stall 3 cycles on hit at pc 0x0010: `instr`/`pc_inc`=0x0012 held stable for 3 edges with `imem_req`=0, then resume with request 0x0012.
- 4-cycle miss at 0x0020 with redirect to 0x0100 in miss cycle 2: `imem_addr` stays 0x0020 until done, data discarded with `valid`=0, next request 0x0100.
- Redirect and halt same cycle, target 0x0040: no HALT entered, next request 0x0040.
- Halt during HOLD at 0x0030: `valid`=0 next cycle and `imem_req`=0 forever. Redirect to 0x0200: fetch resumes at 0x0200.
- PC wrap: redirect to 0xFFFE, hit: `pc_inc`=0x0000, next request 0x0000.
